// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, encodings and helpers for the RV32I instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam int unsigned INSTRUCTION_SIZE = 32;
  localparam int unsigned XLEN             = 32;

  localparam logic [INSTRUCTION_SIZE-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0]             PC_STEP   = 32'd4;

  // Instruction fetches are word aligned; the low two bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] target);
    return {target[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc.sv
// PC register: async reset, load enable, and the redirect / sequential next-PC mux.
module pc_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      if (redirect_valid) begin
        pc_d = redirect_pc;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives the PC to the combinational instruction memory
// and captures the returned word into the IF/ID register, with stall and redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0]             RESET_PC  = 32'h0000_0000,
  parameter logic [INSTRUCTION_SIZE-1:0] NOP_INSTR = instruction_fetch_unit_pkg::NOP_INSTR
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [INSTRUCTION_SIZE-1:0] InstructionAddress,
  input  logic [INSTRUCTION_SIZE-1:0] ReadInstruction,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_target,
  output logic [INSTRUCTION_SIZE-1:0] ifid_instruction,
  output logic [XLEN-1:0]             ifid_pc,
  output logic [XLEN-1:0]             ifid_pc_plus4,
  output logic                        ifid_valid,
  output logic                        fetch_misaligned,
  output logic [31:0]                 fetch_count
);

  logic [XLEN-1:0] pc;
  logic            advance;

  logic [INSTRUCTION_SIZE-1:0] ifid_instruction_d, ifid_instruction_q;
  logic [XLEN-1:0]             ifid_pc_d, ifid_pc_q;
  logic [XLEN-1:0]             ifid_pc_plus4_d, ifid_pc_plus4_q;
  logic                        ifid_valid_d, ifid_valid_q;
  logic                        fetch_misaligned_d, fetch_misaligned_q;
  logic [31:0]                 fetch_count_d, fetch_count_q;

  // A redirect always wins over a stall, so it alone is enough to load the PC.
  assign advance = redirect_valid | ~stall;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk            (clk),
    .reset          (reset),
    .load_en        (advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (align_pc(redirect_target)),
    .pc             (pc)
  );

  assign InstructionAddress = pc;

  always_comb begin
    ifid_instruction_d = ifid_instruction_q;
    ifid_pc_d          = ifid_pc_q;
    ifid_pc_plus4_d    = ifid_pc_plus4_q;
    ifid_valid_d       = ifid_valid_q;
    fetch_misaligned_d = 1'b0;
    fetch_count_d      = fetch_count_q;

    if (redirect_valid) begin
      ifid_instruction_d = NOP_INSTR;
      ifid_pc_d          = '0;
      ifid_pc_plus4_d    = '0;
      ifid_valid_d       = 1'b0;
      fetch_misaligned_d = |redirect_target[1:0];
    end else if (!stall) begin
      ifid_instruction_d = ReadInstruction;
      ifid_pc_d          = pc;
      ifid_pc_plus4_d    = pc + PC_STEP;
      ifid_valid_d       = 1'b1;
      fetch_count_d      = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instruction_q <= NOP_INSTR;
      ifid_pc_q          <= '0;
      ifid_pc_plus4_q    <= '0;
      ifid_valid_q       <= 1'b0;
      fetch_misaligned_q <= 1'b0;
      fetch_count_q      <= '0;
    end else begin
      ifid_instruction_q <= ifid_instruction_d;
      ifid_pc_q          <= ifid_pc_d;
      ifid_pc_plus4_q    <= ifid_pc_plus4_d;
      ifid_valid_q       <= ifid_valid_d;
      fetch_misaligned_q <= fetch_misaligned_d;
      fetch_count_q      <= fetch_count_d;
    end
  end

  assign ifid_instruction = ifid_instruction_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_pc_plus4    = ifid_pc_plus4_q;
  assign ifid_valid       = ifid_valid_q;
  assign fetch_misaligned = fetch_misaligned_q;
  assign fetch_count      = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random
// stall/redirect traffic compared against a behavioural fetch-stage model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] InstructionAddress;
  logic [31:0] ReadInstruction;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        fetch_misaligned;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the fetch stage should hold right now.
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_count;
  logic        m_valid, m_mis;

  instruction_fetch_unit dut (
    .clk                (clk),
    .reset              (reset),
    .InstructionAddress (InstructionAddress),
    .ReadInstruction    (ReadInstruction),
    .stall              (stall),
    .redirect_valid     (redirect_valid),
    .redirect_target    (redirect_target),
    .ifid_instruction   (ifid_instruction),
    .ifid_pc            (ifid_pc),
    .ifid_pc_plus4      (ifid_pc_plus4),
    .ifid_valid         (ifid_valid),
    .fetch_misaligned   (fetch_misaligned),
    .fetch_count        (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: standard program at 0..12, address hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0033;
      32'd4:   return 32'h0010_0093;
      32'd8:   return 32'h0020_0113;
      32'd12:  return 32'h0030_0193;
      default: return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign ReadInstruction = mem_word(InstructionAddress);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h13; m_ipc = 0; m_ipc4 = 0;
    m_valid = 0; m_mis = 0; m_count = 0;
  endtask

  task automatic model_edge(input logic st, input logic rv, input logic [31:0] tg);
    if (rv) begin
      m_pc    = tg - (tg % 4);
      m_instr = 32'h13; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
      m_mis   = (tg % 4) != 0;
    end else if (st) begin
      m_mis = 0;
    end else begin
      m_instr = mem_word(m_pc);
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 32'd4;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
      m_count = m_count + 1;
      m_mis   = 0;
    end
  endtask

  task automatic check_all();
    check("pc",     InstructionAddress, m_pc);
    check("instr",  ifid_instruction,   m_instr);
    check("ifpc",   ifid_pc,            m_ipc);
    check("ifpc4",  ifid_pc_plus4,      m_ipc4);
    check("valid",  {31'b0, ifid_valid}, {31'b0, m_valid});
    check("misal",  {31'b0, fetch_misaligned}, {31'b0, m_mis});
    check("count",  fetch_count,        m_count);
  endtask

  // Apply inputs, take one rising edge, advance the model and compare.
  task automatic step(input logic st, input logic rv, input logic [31:0] tg);
    stall = st; redirect_valid = rv; redirect_target = tg;
    @(posedge clk);
    model_edge(st, rv, tg);
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; stall = 0; redirect_valid = 0; redirect_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_nop", ifid_instruction, 32'h0000_0013);
    #3 reset = 1'b0;

    // Free-running fetch of the standard image.
    repeat (4) step(0, 0, 0);
    check("run4_cnt", fetch_count, 32'd4);
    check("run4_pc",  ifid_pc, 32'd12);
    check("run4_ins", ifid_instruction, 32'h0030_0193);

    // Back to 0, run to PC=8, then stall three cycles.
    step(0, 1, 32'h0);
    check("bubble_valid", {31'b0, ifid_valid}, 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    check("stall_addr", InstructionAddress, 32'd8);
    check("stall_ins",  ifid_instruction, 32'h0010_0093);
    step(0, 0, 0);
    check("release_ins", ifid_instruction, 32'h0020_0113);

    // Redirect to 4 at PC=12 together with a stall.
    step(1, 1, 32'd4);
    check("redir_addr", InstructionAddress, 32'd4);
    check("redir_ins",  ifid_instruction, 32'h0000_0013);
    step(0, 0, 0);
    check("redir_tgt",  ifid_instruction, 32'h0010_0093);

    // Misaligned redirect: aligned to 8, one-cycle flag.
    step(0, 1, 32'h0000_000A);
    check("mis_addr",  InstructionAddress, 32'd8);
    check("mis_flag",  {31'b0, fetch_misaligned}, 32'd1);
    step(0, 0, 0);
    check("mis_clear", {31'b0, fetch_misaligned}, 32'd0);
    check("mis_ins",   ifid_instruction, 32'h0020_0113);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    check("wrap_ifpc",  ifid_pc, 32'hFFFF_FFFC);
    check("wrap_ifpc4", ifid_pc_plus4, 32'h0);
    check("wrap_addr",  InstructionAddress, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic st, rv;
      logic [31:0] tg;
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 6) == 0);
      tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_00FF);
      step(st, rv, tg);
    end

    // Asynchronous reset in the middle of a stalled cycle.
    stall = 1; redirect_valid = 0;
    @(posedge clk);
    model_edge(1, 0, 0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("arst_cnt",  fetch_count, 32'd0);
    check("arst_addr", InstructionAddress, 32'd0);
    #2 reset = 1'b0;
    step(0, 0, 0);
    check("resume_ins", ifid_instruction, 32'h0000_0033);
    check("resume_pc",  ifid_pc, 32'd0);
    step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface for the RV32I pipelined core.
- Owns the PC register and drives InstructionAddress to the combinational InstructionMemory. Captures ReadInstruction into the IF/ID pipeline register.
- Handles stall (hold), redirect (branch/jump flush with bubble insertion), misaligned-target detection and a fetch counter.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush/reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- InstructionAddress  output  `INSTRUCTION_SIZE  current PC, wired directly from the PC register.
- ReadInstruction  input  `INSTRUCTION_SIZE  instruction word returned combinationally by InstructionMemory for InstructionAddress.
- stall  input  1  hazard unit request to hold PC and IF/ID.
- redirect_valid  input  1  taken branch/jump from EX.
- redirect_target  input  32  new PC when redirect_valid=1.
- ifid_instruction  output  32  registered instruction.
- ifid_pc  output  32  PC of ifid_instruction.
- ifid_pc_plus4  output  32  ifid_pc+4, modulo 2^32.
- ifid_valid  output  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.
- fetch_misaligned  output  1  one-cycle pulse: the accepted redirect_target had bits[1:0]≠0.
- fetch_count  output  32  number of instructions captured with ifid_valid=1 since reset; wraps.

Behaviour:
- Reset (asynchronous, active-high; may assert at any point mid-operation), all state cleared immediately:
  - PC=RESET_PC.
  - ifid_instruction=NOP_INSTR, ifid_pc=0, ifid_pc_plus4=0, ifid_valid=0.
  - fetch_misaligned=0, fetch_count=0.
- InstructionAddress=PC at all times; no extra register, so memory data is valid in the same cycle.
- Per rising edge, priority order: reset > redirect_valid > stall > normal.
- Normal (redirect_valid=0, stall=0):
  - IF/ID <= {ReadInstruction, PC, PC+4}, ifid_valid<=1.
  - PC <= PC+4; fetch_count++.
- Stall (redirect_valid=0, stall=1):
  - PC, IF/ID and fetch_count hold.
  - fetch_misaligned<=0.
- Redirect (redirect_valid=1, overrides stall):
  - PC <= {redirect_target[31:2],2'b00}.
  - IF/ID <= {NOP_INSTR, 0, 0}, ifid_valid<=0; fetch_count holds.
  - fetch_misaligned <= |redirect_target[1:0]; otherwise 0 in every non-redirect cycle.
- Latency:
  - Instruction at PC appears on ifid_* one edge after PC presents it.
  - After a redirect: exactly one bubble cycle, then the target instruction.
- Wrap-around:
  - PC=32'hFFFFFFFC advances to 32'h00000000.
  - ifid_pc_plus4 for that fetch is 0.
  - fetch_count FFFFFFFF+1=0.
- All adders are 32-bit; carry is discarded.
- First valid IF/ID occurs on the first rising edge after reset deasserts.

Decomposition:
- Shared include RISCV_PKG.vh gains `INSTRUCTION_SIZE (existing), `XLEN=32, `NOP_INSTR=32'h00000013, `PC_STEP=4.
- One natural sub-module: pc_register (PC flop with async reset, load-enable and next-PC mux).
- The IF/ID register and counter stay in the top module.

Test Plan:
- Reset then 4 free-running edges with the standard image (0:00000033, 4:00100093, 8:00200113, 12:00300193):
  - ifid_instruction sequence 00000033, 00100093, 00200113, 00300193.
  - ifid_pc 0,4,8,12; fetch_count 4.
- Stall asserted for 3 cycles while PC=8:
  - InstructionAddress stays 8; ifid holds 00100093/pc 4; fetch_count unchanged.
  - After release, next capture is 00200113.
- Redirect to 4 at PC=12 (also with stall=1 simultaneously):
  - Next edge: ifid_valid=0, ifid_instruction=00000013, PC=4.
  - Following edge: ifid_instruction=00100093.
- redirect_target=32'h0000000A:
  - PC=8, fetch_misaligned=1 for exactly one cycle.
  - Next capture is 00200113.
- Force PC near top (redirect to FFFFFFFC) and run 2 edges:
  - ifid_pc=FFFFFFFC, ifid_pc_plus4=0, InstructionAddress=0.
- Assert reset asynchronously mid-cycle during a stall:
  - Outputs clear immediately without a clock edge.
  - After deassert, fetch resumes at RESET_PC with 00000033.
